// File: rtl/sw_pe_param.sv
// ============================================================================
//  Module   : sw_pe_param
//  Purpose  : One Smith-Waterman (affine gap) processing element of a linear
//             systolic array. Holds one query symbol, scores each streamed
//             target symbol, and forwards H/F/running-max downstream with a
//             fixed two-cycle latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_pe_param #(
    parameter int SCORE_W = 12,
    parameter int SYM_W   = 2,
    parameter int COL_W   = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SCORE_W-1:0]  match_i,
    input  logic signed [SCORE_W-1:0]  mismatch_i,
    input  logic signed [SCORE_W-1:0]  alpha_i,
    input  logic signed [SCORE_W-1:0]  beta_i,
    input  logic                       q_load_i,
    input  logic        [SYM_W-1:0]    q_sym_i,
    input  logic                       in_valid_i,
    input  logic                       in_last_i,
    input  logic        [SYM_W-1:0]    in_sym_i,
    input  logic signed [SCORE_W-1:0]  in_v_i,
    input  logic signed [SCORE_W-1:0]  in_f_i,
    input  logic signed [SCORE_W-1:0]  in_max_i,
    output logic                       out_valid_o,
    output logic                       out_last_o,
    output logic        [SYM_W-1:0]    out_sym_o,
    output logic signed [SCORE_W-1:0]  out_v_o,
    output logic signed [SCORE_W-1:0]  out_f_o,
    output logic signed [SCORE_W-1:0]  out_max_o,
    output logic        [COL_W-1:0]    max_col_o,
    output logic        [1:0]          state_o,
    output logic                       q_err_o
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam logic signed [SCORE_W-1:0] SMAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SMIN = {1'b1, {(SCORE_W-1){1'b0}}};

    // Add with one guard bit, clamping to the representable range on overflow.
    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        logic signed [SCORE_W:0] sum;
        sum = $signed({a[SCORE_W-1], a}) + $signed({b[SCORE_W-1], b});
        if (sum[SCORE_W] != sum[SCORE_W-1])
            return sum[SCORE_W] ? SMIN : SMAX;
        return sum[SCORE_W-1:0];
    endfunction

    function automatic logic signed [SCORE_W-1:0] smax(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    state_t                      state_q, state_d;
    logic        [SYM_W-1:0]     q_q, q_d;
    logic                        q_err_q, q_err_d;

    // Per-sequence recurrence state (all zero at sequence start)
    logic signed [SCORE_W-1:0]   diag_q, e_q, hp_q, best_q;
    logic        [COL_W-1:0]     col_q, bestcol_q;

    // Two-stage output pipeline
    logic                        s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
    logic        [SYM_W-1:0]     s1_sym_q, s2_sym_q;
    logic signed [SCORE_W-1:0]   s1_v_q, s1_f_q, s1_max_q, s2_v_q, s2_f_q, s2_max_q;
    logic        [COL_W-1:0]     s1_col_q, s2_col_q;

    logic                        accept;
    logic signed [SCORE_W-1:0]   w_s, w_f, w_e, w_h, w_max;
    logic                        w_better;
    logic        [COL_W-1:0]     w_maxcol;

    // Next-state, query capture and illegal-load detection
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        q_err_d = q_err_q;
        case (state_q)
            ST_EMPTY: begin
                if (q_load_i) begin
                    q_d     = q_sym_i;
                    state_d = ST_LOADED;
                end
            end
            ST_LOADED: begin
                if (q_load_i)
                    q_d = q_sym_i;
                if (in_valid_i && !in_last_i)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                if (q_load_i)
                    q_err_d = 1'b1;
                if (in_valid_i && in_last_i)
                    state_d = ST_LOADED;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Cell score for the current beat; a beat arriving while EMPTY is only forwarded
    always_comb begin
        accept   = in_valid_i && (state_q != ST_EMPTY);
        w_s      = (in_sym_i == q_q) ? match_i : mismatch_i;
        w_f      = smax(sat_add(in_f_i, beta_i), sat_add(in_v_i, alpha_i));
        w_e      = smax(sat_add(e_q, beta_i), sat_add(hp_q, alpha_i));
        w_h      = smax(smax('0, sat_add(diag_q, w_s)), smax(w_e, w_f));
        w_max    = smax(in_max_i, w_h);
        w_better = w_h > best_q;
        w_maxcol = w_better ? col_q : bestcol_q;
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            q_q     <= '0;
            q_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            q_err_q <= q_err_d;
        end
    end

    // Recurrence state: advance on accepted beats, clear after the last column
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diag_q    <= '0;
            e_q       <= '0;
            hp_q      <= '0;
            best_q    <= '0;
            col_q     <= '0;
            bestcol_q <= '0;
        end else if (accept) begin
            if (in_last_i) begin
                diag_q    <= '0;
                e_q       <= '0;
                hp_q      <= '0;
                best_q    <= '0;
                col_q     <= '0;
                bestcol_q <= '0;
            end else begin
                diag_q    <= in_v_i;
                e_q       <= w_e;
                hp_q      <= w_h;
                best_q    <= w_better ? w_h : best_q;
                col_q     <= col_q + COL_W'(1);
                bestcol_q <= w_maxcol;
            end
        end
    end

    // Output pipeline: valid always advances, payload holds across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sym_q   <= '0;
            s1_v_q     <= '0;
            s1_f_q     <= '0;
            s1_max_q   <= '0;
            s1_col_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_sym_q   <= '0;
            s2_v_q     <= '0;
            s2_f_q     <= '0;
            s2_max_q   <= '0;
            s2_col_q   <= '0;
        end else begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_last_q <= in_last_i;
                s1_sym_q  <= in_sym_i;
                s1_v_q    <= accept ? w_h      : in_v_i;
                s1_f_q    <= accept ? w_f      : in_f_i;
                s1_max_q  <= accept ? w_max    : in_max_i;
                s1_col_q  <= accept ? w_maxcol : s1_col_q;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_last_q <= s1_last_q;
                s2_sym_q  <= s1_sym_q;
                s2_v_q    <= s1_v_q;
                s2_f_q    <= s1_f_q;
                s2_max_q  <= s1_max_q;
                s2_col_q  <= s1_col_q;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_last_o  = s2_last_q;
    assign out_sym_o   = s2_sym_q;
    assign out_v_o     = s2_v_q;
    assign out_f_o     = s2_f_q;
    assign out_max_o   = s2_max_q;
    assign max_col_o   = s2_col_q;
    assign state_o     = state_q;
    assign q_err_o     = q_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_pe_param.sv
// ============================================================================
//  Module   : tb_sw_pe_param
//  Purpose  : Directed self-checking bench for sw_pe_param (SCORE_W=8,
//             match 2, mismatch -1, gap open -3, gap extend -1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_pe_param;

    localparam int SW = 8;
    localparam int YW = 2;
    localparam int CW = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic signed [SW-1:0] match_i, mismatch_i, alpha_i, beta_i;
    logic                 q_load_i;
    logic        [YW-1:0] q_sym_i;
    logic                 in_valid_i, in_last_i;
    logic        [YW-1:0] in_sym_i;
    logic signed [SW-1:0] in_v_i, in_f_i, in_max_i;
    logic                 out_valid_o, out_last_o;
    logic        [YW-1:0] out_sym_o;
    logic signed [SW-1:0] out_v_o, out_f_o, out_max_o;
    logic        [CW-1:0] max_col_o;
    logic        [1:0]    state_o;
    logic                 q_err_o;

    int checks   = 0;
    int failures = 0;

    // Recorded outputs of valid beats during the bubble comparison runs
    int rec_n;
    int rec_v [8];
    int rec_f [8];
    int rec_c [8];

    always #5 clk = ~clk;

    sw_pe_param #(.SCORE_W(SW), .SYM_W(YW), .COL_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .match_i    (match_i),
        .mismatch_i (mismatch_i),
        .alpha_i    (alpha_i),
        .beta_i     (beta_i),
        .q_load_i   (q_load_i),
        .q_sym_i    (q_sym_i),
        .in_valid_i (in_valid_i),
        .in_last_i  (in_last_i),
        .in_sym_i   (in_sym_i),
        .in_v_i     (in_v_i),
        .in_f_i     (in_f_i),
        .in_max_i   (in_max_i),
        .out_valid_o(out_valid_o),
        .out_last_o (out_last_o),
        .out_sym_o  (out_sym_o),
        .out_v_o    (out_v_o),
        .out_f_o    (out_f_o),
        .out_max_o  (out_max_o),
        .max_col_o  (max_col_o),
        .state_o    (state_o),
        .q_err_o    (q_err_o)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic beat(input logic v, input logic l, input logic [YW-1:0] s,
                        input int vv, input int ff, input int mm);
        in_valid_i = v;
        in_last_i  = l;
        in_sym_i   = s;
        in_v_i     = SW'(vv);
        in_f_i     = SW'(ff);
        in_max_i   = SW'(mm);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, '0, 0, 0, 0);
    endtask

    task automatic tickrec();
        tick();
        if (out_valid_o && rec_n < 8) begin
            rec_v[rec_n] = int'(out_v_o);
            rec_f[rec_n] = int'(out_f_o);
            rec_c[rec_n] = int'(max_col_o);
            rec_n++;
        end
    endtask

    // Four-beat sequence, optionally with one bubble after each of the first three
    task automatic run_seq(input bit bubbles);
        logic [YW-1:0] sy [4];
        int vv [4];
        int ff [4];
        int ev [4];
        int ef [4];
        int ec [4];
        sy = '{2'd0, 2'd0, 2'd1, 2'd0};
        vv = '{5, 3, 1, 0};
        ff = '{0, 0, 4, 0};
        ev = '{2, 7, 4, 3};
        ef = '{2, 0, 3, -1};
        ec = '{0, 1, 1, 1};
        rec_n = 0;
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, (i == 3), sy[i], vv[i], ff[i], 0);
            tickrec();
            if (bubbles && i < 3) begin
                idle();
                tickrec();
            end
        end
        idle();
        repeat (3) tickrec();
        chk(bubbles ? "bub_count" : "seq_count", rec_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk(bubbles ? "bub_v" : "seq_v", rec_v[i], ev[i]);
            chk(bubbles ? "bub_f" : "seq_f", rec_f[i], ef[i]);
            chk(bubbles ? "bub_col" : "seq_col", rec_c[i], ec[i]);
        end
    endtask

    initial begin
        match_i    = 8'sd2;
        mismatch_i = -8'sd1;
        alpha_i    = -8'sd3;
        beta_i     = -8'sd1;
        q_load_i   = 1'b0;
        q_sym_i    = '0;
        idle();

        // Reset state
        repeat (2) tick();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_v", out_v_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_qerr", q_err_o, 0);
        rst_n = 1'b1;
        tick();

        // EMPTY forwards the beat untouched
        beat(1'b1, 1'b0, 2'd3, 17, -5, 9);
        tick(); idle(); tick();
        chk("pt_valid", out_valid_o, 1);
        chk("pt_v", $signed(out_v_o), 17);
        chk("pt_f", $signed(out_f_o), -5);
        chk("pt_max", $signed(out_max_o), 9);
        chk("pt_sym", out_sym_o, 3);
        chk("pt_state", state_o, 0);

        // Load query 0
        q_load_i = 1'b1; q_sym_i = 2'd0;
        tick();
        q_load_i = 1'b0;
        chk("load_state", state_o, 1);

        // Single matching beat from zero inputs
        beat(1'b1, 1'b1, 2'd0, 0, 0, 0);
        tick(); idle(); tick();
        chk("m1_v", $signed(out_v_o), 2);
        chk("m1_f", $signed(out_f_o), -1);
        chk("m1_max", $signed(out_max_o), 2);
        chk("m1_col", max_col_o, 0);
        chk("m1_last", out_last_o, 1);
        chk("m1_state", state_o, 1);

        // Saturation: mismatch near top, then diag 126+2 clamps
        beat(1'b1, 1'b0, 2'd1, 126, 0, 0);
        tick();
        beat(1'b1, 1'b0, 2'd0, 0, 0, 0);
        chk("run_state", state_o, 2);
        tick();
        beat(1'b1, 1'b1, 2'd0, 50, 0, 0);
        chk("sat1_v", $signed(out_v_o), 123);
        chk("sat1_max", $signed(out_max_o), 123);
        tick();
        idle();
        chk("sat2_v", $signed(out_v_o), 127);
        chk("sat2_max", $signed(out_max_o), 127);
        chk("sat2_col", max_col_o, 1);
        tick();
        chk("last_v", $signed(out_v_o), 124);
        chk("last_state", state_o, 1);

        // New sequence starts from cleared diag/E/H/column
        beat(1'b1, 1'b0, 2'd0, 0, 0, 0);
        tick(); idle();
        chk("new_state", state_o, 2);
        tick();
        chk("new_v", $signed(out_v_o), 2);
        chk("new_col", max_col_o, 0);

        // Illegal query load while running
        q_load_i = 1'b1; q_sym_i = 2'd1;
        tick();
        q_load_i = 1'b0;
        chk("qerr_set", q_err_o, 1);
        chk("qerr_state", state_o, 2);
        beat(1'b1, 1'b1, 2'd0, 0, 0, 0);
        tick(); idle(); tick();
        chk("qkeep_v", $signed(out_v_o), 2);
        chk("qkeep_col", max_col_o, 0);
        chk("qerr_sticky", q_err_o, 1);

        // Bubbles must not change the results
        run_seq(1'b0);
        run_seq(1'b1);

        // Asynchronous reset in the middle of a sequence
        beat(1'b1, 1'b0, 2'd0, 0, 0, 0);
        tick(); idle(); tick();
        chk("pre_rst_v", $signed(out_v_o), 2);
        chk("pre_rst_state", state_o, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid_o, 0);
        chk("arst_v", out_v_o, 0);
        chk("arst_f", out_f_o, 0);
        chk("arst_max", out_max_o, 0);
        chk("arst_col", max_col_o, 0);
        chk("arst_state", state_o, 0);
        chk("arst_qerr", q_err_o, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sw_pe_param.md
SW_PE_PARAM -- requirements
Module: sw_pe_param

Interface
REQ-001 SHALL have parameter SCORE_W, default 12, signed score width (min 6).
REQ-002 SHALL have parameter SYM_W, default 2, symbol width (2 = DNA, 5 = protein).
REQ-003 SHALL have parameter COL_W, default 10, column-counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 match_i, mismatch_i, alpha_i, beta_i  in  SCORE_W each  signed scores; alpha_i is gap open (total), beta_i is gap extend; static while state is RUN.
REQ-007 q_load_i  in  1, q_sym_i  in  SYM_W  query symbol load strobe and symbol.
REQ-008 in_valid_i  in  1, in_last_i  in  1, in_sym_i  in  SYM_W  target beat, last-column flag, target symbol.
REQ-009 in_v_i, in_f_i, in_max_i  in  SCORE_W  upstream H, upstream F, running max.
REQ-010 out_valid_o, out_last_o  out  1, out_sym_o  out  SYM_W  forwarded beat.
REQ-011 out_v_o, out_f_o, out_max_o  out  SCORE_W  this PE's H, F, running max.
REQ-012 max_col_o  out  COL_W  column of this PE's best H in the current sequence.
REQ-013 state_o  out  2  EMPTY=0, LOADED=1, RUN=2; q_err_o  out  1  sticky illegal-load flag.

Function
REQ-014 SHALL use states EMPTY -> LOADED (q_load_i) -> RUN (first in_valid_i) -> LOADED (accepted beat with in_last_i=1).
REQ-015 q_load_i in EMPTY or LOADED SHALL capture q_sym_i and enter/stay LOADED; in RUN it SHALL be ignored and set q_err_o=1.
REQ-016 in_valid_i in EMPTY SHALL be forwarded unchanged with no score update (pass-through, out_v_o = in_v_i, out_f_o = in_f_i, out_max_o = in_max_i).
REQ-017 Per accepted beat: s = (in_sym_i == q) ? match_i : mismatch_i; diag = in_v_i of previous accepted beat (0 at sequence start).
REQ-018 F = max(in_f_i + beta_i, in_v_i + alpha_i); E = max(E_prev + beta_i, H_prev + alpha_i), E_prev and H_prev = 0 at sequence start.
REQ-019 H = max(0, diag + s, E, F), all comparisons signed.
REQ-020 Every addition SHALL saturate to [-2^(SCORE_W-1), 2^(SCORE_W-1)-1]; no wrap-around.
REQ-021 out_v_o = H, out_f_o = F, out_max_o = max(in_max_i, H) (signed).
REQ-022 All out_* SHALL appear exactly 2 cycles after the accepted beat; out_valid_o, out_last_o, out_sym_o delayed identically.
REQ-023 in_valid_i=0 cycles (bubbles) SHALL not alter diag, E, H_prev or the column counter; out_valid_o=0 two cycles later, other outputs hold.
REQ-024 Column counter SHALL reset to 0 at sequence start, increment per accepted beat, wrap at 2^COL_W.
REQ-025 max_col_o SHALL update only when H strictly exceeds the best H so far (earliest column wins ties); best and max_col_o cleared at sequence start.
REQ-026 After a beat with in_last_i=1: diag, E_prev, H_prev, column counter, best H cleared for the next sequence; query retained.
REQ-027 No backpressure; one beat per cycle sustained.

Reset
REQ-028 rst_n low SHALL immediately clear all outputs, pipelines, query, E/diag/best, counter to 0, state to EMPTY, q_err_o to 0, including mid-sequence.
REQ-029 After rst_n release, first beat SHALL be accepted no earlier than the following rising edge.

Verification (SCORE_W=8, match 2, mismatch -1, alpha -3, beta -1)
REQ-030 Reset asserted mid-RUN -> all outputs 0, state_o=0 same cycle, q_err_o=0.
REQ-031 Load q=0, beat sym=0, in_v=0, in_f=0 -> 2 cycles later out_v=2, out_f=-1, out_max=2, max_col=0.
REQ-032 q=0; beat1 sym=1, in_v=126; beat2 sym=0, in_v=0 -> beat1 out_v=123, beat2 diag 126+2 saturates, out_v=127.
REQ-033 Beat sym=0 with in_last=1, then new beat sym=0, in_v=0 -> second out_v=2 (diag cleared), max_col=0, state LOADED->RUN.
REQ-034 q_load_i during RUN -> query unchanged, q_err_o=1 until reset.
REQ-035 Same beat sequence with and without 3 inserted bubbles -> identical out_v/out_f/max_col sequence on out_valid_o beats.
